fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly downstream of the pc register. Reads the
//  current pc address, fetches from instruction memory over a req/ack
//  handshake and buffers instructions in a small queue toward decode.
//  Drives the pc's en_pc/adrs_in pair: sequential advance or branch redirect.
// PARAMETERS
//  ADDR_W   8   address width; must match pc adrs_in/adrs_out
//  INSTR_W  8   instruction word width
//  QDEPTH   2   instruction queue entries (power of 2, >=2)
// PORTS
//  clk            in   1        clock, all state on rising edge
//  clr            in   1        reset, asynchronous, active-low
//  pc_adrs        in   ADDR_W   current pc (pc adrs_out)
//  en_pc          out  1        pc load enable (pc en_pc)
//  adrs_next      out  ADDR_W   next pc value (pc adrs_in)
//  mem_req        out  1        memory request
//  mem_adrs       out  ADDR_W   memory address (= pc_adrs)
//  mem_ack        in   1        memory ack; mem_data valid this cycle
//  mem_data       in   INSTR_W  fetched instruction
//  ir_valid       out  1        queue head valid to decode
//  ir_ready       in   1        decode accepts head
//  ir_data        out  INSTR_W  head instruction
//  ir_adrs        out  ADDR_W   address of head instruction
//  redirect       in   1        branch taken, single-cycle pulse
//  redirect_adrs  in   ADDR_W   branch target
// BEHAVIOUR
//  - clr=0: state IDLE, queue count 0, redir_adrs 0; en_pc, mem_req, ir_valid 0;
//    adrs_next, ir_data, ir_adrs 0. mem_req drops at once, no clock needed.
//  - FSM states: IDLE, REQ, SQUASH, REDIR.
//    IDLE -> REQ when count<QDEPTH and no redirect.
//    REQ: mem_req=1, mem_adrs=pc_adrs, held until mem_ack.
//      ack, no redirect: push {pc_adrs,mem_data}; en_pc=1 same cycle with
//      adrs_next=pc_adrs+1, mod 2^ADDR_W (0xFF->0x00). Stay REQ if post-push
//      count<QDEPTH, else IDLE.
//      redirect with ack: data dropped, no push -> REDIR.
//      redirect without ack -> SQUASH.
//    SQUASH: mem_req held (no abandoning a request); ack data dropped -> REDIR.
//    REDIR: one cycle, en_pc=1, adrs_next=redir_adrs -> IDLE.
//  - redirect in any state: redir_adrs<=redirect_adrs; queue flushed on same
//    edge (ir_valid=0 next cycle). From IDLE -> REDIR. New redirect in
//    SQUASH/REDIR overwrites redir_adrs; REDIR repeats with new target.
//  - en_pc is 0 in all other cycles; then adrs_next=pc_adrs+1 (don't care).
//  - Queue: circular, head on ir_data/ir_adrs; pop on ir_valid&ir_ready.
//    Push and pop on the same edge hold count. Redirect beats pop/push.
//  - Latency: ack to ir_valid 1 cycle; pc update visible the cycle after en_pc.
//  - Max 1 outstanding request; mem_adrs stable for whole request.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: empty queue with ir_ready=1 in an accepted ack
//   cycle: mem_data/pc_adrs go to ir_data/ir_adrs combinationally, ir_valid=1
//   that cycle, no push (0-cycle latency).
//  undefined: all instructions pass through queue (1-cycle latency).
// TESTING
//  1 Reset: clr=0 mid-REQ -> mem_req/en_pc/ir_valid 0 with no clock edge;
//    release, pc=0x00 -> mem_req=1, mem_adrs=0x00 next cycle.
//  2 Stream: ack every request, ir_ready=1, data 0xA0,0xA1,0xA2 at pc 0x00-0x02
//    -> en_pc per ack, adrs_next 0x01,0x02,0x03; decode gets same order/adrs.
//  3 Backpressure: ir_ready=0, QDEPTH=2 -> 2 pushes, mem_req drops, IDLE;
//    ir_ready=1 -> one pop, fetch resumes next cycle.
//  4 Wrap: ack at pc_adrs=0xFF -> en_pc=1, adrs_next=0x00.
//  5 Redirect to 0x40 in REQ, ack 2 cycles later -> ir_valid 0 next cycle,
//    ack data not delivered, then en_pc with adrs_next=0x40, next mem_adrs 0x40.
//  6 FETCH_BYPASS_EN: empty queue, ir_ready=1, ack 0x5C -> ir_valid=1,
//    ir_data=0x5C in ack cycle; undefined -> one cycle later.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the pc register and decode.
// Issues one memory request at a time for the current pc, advances the pc on
// every accepted fetch, buffers fetched words in a small circular queue and
// handles branch redirects (in-flight data is squashed, queue flushed).
// Optional build macro: FETCH_BYPASS_EN -- an accepted fetch that finds the
// queue empty and decode ready goes straight to decode in the same cycle.
module fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8,
    parameter int QDEPTH  = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [ADDR_W-1:0]  pc_adrs,
    output logic               en_pc,
    output logic [ADDR_W-1:0]  adrs_next,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_adrs,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_adrs,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_adrs
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_SQUASH = 2'd2,
        S_REDIR  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_redir_adrs;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [INSTR_W-1:0] r_q_data [QDEPTH];
    logic [ADDR_W-1:0]  r_q_adrs [QDEPTH];

    logic               w_ack_ok;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_head_valid;
    logic [CNT_W-1:0]   w_count_after;

    // Qualify the handshakes: accepted fetch, optional bypass, queue push/pop.
    always_comb begin
        w_ack_ok     = (r_state == S_REQ) && mem_ack && !redirect;
        w_head_valid = (r_count != {CNT_W{1'b0}});
`ifdef FETCH_BYPASS_EN
        w_bypass     = w_ack_ok && !w_head_valid && ir_ready;
`else
        w_bypass     = 1'b0;
`endif
        w_push        = w_ack_ok && !w_bypass;
        w_pop         = w_head_valid && ir_ready && !redirect;
        w_count_after = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Drive pc, memory and decode-side outputs.
    always_comb begin
        mem_req  = r_mem_req;
        mem_adrs = pc_adrs;
        en_pc    = w_ack_ok || (r_state == S_REDIR);
        if (!clr) begin
            adrs_next = {ADDR_W{1'b0}};
        end else if (r_state == S_REDIR) begin
            adrs_next = r_redir_adrs;
        end else begin
            adrs_next = pc_adrs + ADDR_W'(1);
        end
        ir_valid = w_head_valid || w_bypass;
        if (w_bypass) begin
            ir_data = mem_data;
            ir_adrs = pc_adrs;
        end else begin
            ir_data = r_q_data[r_rd_ptr];
            ir_adrs = r_q_adrs[r_rd_ptr];
        end
    end

    // Fetch control FSM; mem_req is registered alongside the state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_redir_adrs <= {ADDR_W{1'b0}};
        end else if (redirect) begin
            r_redir_adrs <= redirect_adrs;
            case (r_state)
                S_IDLE: begin
                    r_state   <= S_REDIR;
                    r_mem_req <= 1'b0;
                end
                S_REQ, S_SQUASH: begin
                    // An open request is never abandoned: wait out its ack.
                    if (mem_ack) begin
                        r_state   <= S_REDIR;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_state   <= S_SQUASH;
                        r_mem_req <= 1'b1;
                    end
                end
                S_REDIR: begin
                    r_state   <= S_REDIR;
                    r_mem_req <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < FULL) begin
                        r_state   <= S_REQ;
                        r_mem_req <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_ack && !(w_count_after < FULL)) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_state   <= S_REQ;
                        r_mem_req <= 1'b1;
                    end
                end
                S_SQUASH: begin
                    if (mem_ack) begin
                        r_state   <= S_REDIR;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_state   <= S_SQUASH;
                        r_mem_req <= 1'b1;
                    end
                end
                S_REDIR: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Instruction queue: circular buffer, flushed by redirect.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_count  <= {CNT_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_data[i] <= {INSTR_W{1'b0}};
                r_q_adrs[i] <= {ADDR_W{1'b0}};
            end
        end else if (redirect) begin
            r_count  <= {CNT_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_q_data[r_wr_ptr] <= mem_data;
                r_q_adrs[r_wr_ptr] <= pc_adrs;
                r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= w_count_after;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: pc register and memory models around the DUT, a
// randomized driver that pushes expected results into scoreboards, and a
// monitor that pops and compares whenever the DUT presents an output.
module tb_fetch_unit;

    localparam int QD = 2;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] pc_r;
    logic       en_pc;
    logic [7:0] adrs_next;
    logic       mem_req;
    logic [7:0] mem_adrs;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       ir_valid;
    logic       ir_ready;
    logic [7:0] ir_data;
    logic [7:0] ir_adrs;
    logic       redirect;
    logic [7:0] redirect_adrs;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .INSTR_W(8), .QDEPTH(QD)) dut (
        .clk(clk), .clr(clr), .pc_adrs(pc_r), .en_pc(en_pc), .adrs_next(adrs_next),
        .mem_req(mem_req), .mem_adrs(mem_adrs), .mem_ack(mem_ack), .mem_data(mem_data),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_adrs(ir_adrs),
        .redirect(redirect), .redirect_adrs(redirect_adrs)
    );

    // pc register model
    always @(posedge clk or negedge clr) begin
        if (!clr) pc_r <= 8'h00;
        else if (en_pc) pc_r <= adrs_next;
    end

    typedef struct { logic [7:0] adrs; logic [7:0] data; } item_t;
    typedef struct { bit en; logic [7:0] nxt; bit chk; logic [7:0] adr; } ack_t;

    item_t expq[$];
    ack_t  ackq[$];
    logic [7:0] mem [256];

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    int k_ready_pct = 100;
    int k_lat_max = 0;
    bit k_ack_en = 1'b1;
    bit k_redir_en = 1'b0;
    bit k_force = 1'b0;
    logic [7:0] k_force_tgt = 8'h00;
    bit in_req = 1'b0;
    bit squashed = 1'b0;
    bit pending_redir = 1'b0;
    int lat_cnt = 0;
    int cooldown = 0;
    int n_accept = 0;
    int n_wrap = 0;
    logic [7:0] exp_pc = 8'h00;
    logic [7:0] last_tgt = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; expected results go into the scoreboards here.
    task automatic drive_cycle();
        logic [7:0] tgt;
        mem_ack  = 1'b0;
        redirect = 1'b0;
        ir_ready = ($urandom_range(99) < k_ready_pct);
        if (cooldown > 0) cooldown--;
        if (mem_req && !in_req) begin
            in_req  = 1'b1;
            lat_cnt = $urandom_range(k_lat_max);
        end
        if (k_force || (k_redir_en && cooldown == 0 && $urandom_range(9) == 0)) begin
            if (k_force) tgt = k_force_tgt;
            else if ($urandom_range(3) == 0) tgt = 8'hFC + 8'($urandom_range(3));
            else tgt = 8'($urandom);
            k_force       = 1'b0;
            redirect      = 1'b1;
            redirect_adrs = tgt;
            cooldown      = 10;
            if (mem_req) squashed = 1'b1;
            expq.delete();
            exp_pc        = tgt;
            last_tgt      = tgt;
            pending_redir = 1'b1;
        end
        if (in_req) begin
            if (k_ack_en && lat_cnt == 0) begin
                mem_ack  = 1'b1;
                mem_data = mem[mem_adrs];
                in_req   = 1'b0;
                if (squashed) begin
                    squashed = 1'b0;
                    ackq.push_back('{1'b0, 8'h00, 1'b0, 8'h00});
                end else begin
                    ackq.push_back('{1'b1, exp_pc + 8'h01, 1'b1, exp_pc});
                    expq.push_back('{exp_pc, mem[exp_pc]});
                    if (exp_pc == 8'hFF) n_wrap++;
                    exp_pc = exp_pc + 8'h01;
                    n_accept++;
                end
            end else if (lat_cnt > 0) begin
                lat_cnt--;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        k_ack_en    = 1'b0;
        k_redir_en  = 1'b0;
        k_ready_pct = 100;
        run_cycles(8);
        check("drain_empty", expq.size(), 0);
    endtask

    // Monitor: compares DUT outputs against the scoreboards.
    always @(negedge clk) begin : monitor
        ack_t  a;
        item_t it;
        if (mon_en) begin
            if (mem_req && mem_ack) begin
                if (ackq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ack_scoreboard: got unexpected ack expected none (t=%0t)", $time);
                end else begin
                    a = ackq.pop_front();
                    check("en_pc_on_ack", en_pc, a.en);
                    if (a.en) check("adrs_next_on_ack", adrs_next, a.nxt);
                    if (a.chk) check("mem_adrs", mem_adrs, a.adr);
                end
            end else if (en_pc) begin
                check("redir_pending", pending_redir, 1);
                check("adrs_next_redir", adrs_next, last_tgt);
                pending_redir = 1'b0;
            end
            if (expq.size() > QD) begin
                total++; bad++;
                $display("FAIL queue_bound: got %0d expected <= %0d", expq.size(), QD);
            end
            if (ir_valid && ir_ready && !redirect) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ir_scoreboard: got data 0x%0h expected nothing (t=%0t)", ir_data, $time);
                end else begin
                    it = expq.pop_front();
                    check("ir_data", ir_data, it.data);
                    check("ir_adrs", ir_adrs, it.adrs);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        clr = 1'b0; mem_ack = 1'b0; mem_data = 8'h00; ir_ready = 1'b0;
        redirect = 1'b0; redirect_adrs = 8'h00;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_en_pc", en_pc, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_adrs_next", adrs_next, 0);
        check("rst_ir_data", ir_data, 0);
        check("rst_ir_adrs", ir_adrs, 0);
        @(negedge clk) clr = 1'b1;
        @(posedge clk); #1;
        check("rel_mem_req", mem_req, 1);
        check("rel_mem_adrs", mem_adrs, 8'h00);

        // asynchronous reset in the middle of a request
        #2 clr = 1'b0;
        #1;
        check("async_mem_req", mem_req, 0);
        check("async_en_pc", en_pc, 0);
        check("async_ir_valid", ir_valid, 0);
        @(negedge clk) clr = 1'b1;
        @(posedge clk); #1;
        check("rel2_mem_req", mem_req, 1);
        check("rel2_mem_adrs", mem_adrs, 8'h00);

        // streaming, then random traffic with redirects
        mon_en = 1'b1;
        k_ready_pct = 100; k_lat_max = 0; k_ack_en = 1'b1; k_redir_en = 1'b0;
        run_cycles(20);
        k_ready_pct = 60; k_lat_max = 3; k_redir_en = 1'b1;
        run_cycles(3000);

        // backpressure
        drain();
        k_ack_en = 1'b1; k_lat_max = 0; k_ready_pct = 0;
        run_cycles(12);
        check("bp_mem_req", mem_req, 0);
        check("bp_queued", expq.size(), QD);
        k_ready_pct = 100;
        run_cycles(1);
        k_ready_pct = 0;
        run_cycles(1);
        check("bp_resume", mem_req, 1);

        // redirect to 0x40 while a request is open, ack arrives later
        k_ack_en = 1'b0; k_force = 1'b1; k_force_tgt = 8'h40;
        run_cycles(1);
        check("redir_flush", ir_valid, 0);
        run_cycles(1);
        k_ack_en = 1'b1; k_ready_pct = 100;
        run_cycles(10);

        // pc wrap 0xFF -> 0x00
        k_force = 1'b1; k_force_tgt = 8'hFE;
        run_cycles(12);
        check("wrap_seen", (n_wrap > 0), 1);

        // bypass latency
        drain();
        mem[exp_pc] = 8'h5C;
        k_ack_en = 1'b1; k_lat_max = 0; k_ready_pct = 100;
        drive_cycle();
        k_ack_en = 1'b0;
        @(negedge clk);
`ifdef FETCH_BYPASS_EN
        check("byp_valid_ack_cycle", ir_valid, 1);
        check("byp_data_ack_cycle", ir_data, 8'h5C);
`else
        check("byp_valid_ack_cycle", ir_valid, 0);
`endif
        @(posedge clk); #1;
        drive_cycle();
        @(negedge clk);
`ifdef FETCH_BYPASS_EN
        check("byp_valid_next_cycle", ir_valid, 0);
`else
        check("byp_valid_next_cycle", ir_valid, 1);
        check("byp_data_next_cycle", ir_data, 8'h5C);
`endif
        @(posedge clk); #1;

        // final drain
        drain();
        check("end_ackq", ackq.size(), 0);
        check("end_pending_redir", pending_redir, 0);
        check("end_ir_valid", ir_valid, 0);
        check("accept_count", (n_accept > 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
